// File: rtl/pipe_hazard_ctrl.sv
// Hazard/pipeline control for the 5-stage RV32 core: post-reset bubble fill,
// load-use stall, branch/jump redirect, and performance event counters.
module pipe_hazard_ctrl #(
    parameter int unsigned INIT_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        ex_memRead,
    input  logic [4:0]  ex_rd,
    input  logic        mem_branch,
    input  logic        mem_zero,
    input  logic        mem_bne,
    input  logic        mem_jump,
    input  logic        cnt_clr,
    output logic        pc_write,
    output logic        pc_sel,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic        mem_wb_flush,
    output logic [31:0] cycle_cnt,
    output logic [31:0] stall_cnt,
    output logic [31:0] redirect_cnt
);

    localparam int unsigned INIT_W = 4;
    localparam int unsigned CNT_W  = 32;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [INIT_W-1:0]   r_init_cnt;
    logic [INIT_W-1:0]   w_init_cnt_nxt;
    logic [CNT_W-1:0]    r_cycle_cnt;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    r_redirect_cnt;
    logic                w_taken;
    logic                w_load_use;

    // Hazard decode from the current stage-register outputs
    assign w_taken    = mem_jump | (mem_branch & (mem_zero ^ mem_bne));
    assign w_load_use = ex_memRead & (ex_rd != 5'd0) &
                        ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                         (id_uses_rs2 & (id_rs2 == ex_rd)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_cnt <= w_init_cnt_nxt;
        end
    end

    // Next state plus Mealy pipeline controls; redirect outranks the stall
    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        pc_write       = 1'b1;
        pc_sel         = 1'b0;
        if_id_write    = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        ex_mem_flush   = 1'b0;
        mem_wb_flush   = 1'b0;
        case (r_state)
            ST_INIT: begin
                pc_write       = 1'b0;
                if_id_write    = 1'b0;
                if_id_flush    = 1'b1;
                id_ex_flush    = 1'b1;
                ex_mem_flush   = 1'b1;
                mem_wb_flush   = 1'b1;
                w_init_cnt_nxt = r_init_cnt + INIT_W'(1);
                if (r_init_cnt == INIT_W'(INIT_CYCLES - 1)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_taken) begin
                    pc_sel       = 1'b1;
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    ex_mem_flush = 1'b1;
                end else if (w_load_use) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // Event counters advance only while running; clear wins over increments
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_cnt    <= '0;
            r_stall_cnt    <= '0;
            r_redirect_cnt <= '0;
        end else if (r_state == ST_RUN) begin
            if (cnt_clr) begin
                r_cycle_cnt    <= '0;
                r_stall_cnt    <= '0;
                r_redirect_cnt <= '0;
            end else begin
                r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
                if (w_taken) begin
                    r_redirect_cnt <= r_redirect_cnt + CNT_W'(1);
                end else if (w_load_use) begin
                    r_stall_cnt <= r_stall_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign cycle_cnt    = r_cycle_cnt;
    assign stall_cnt    = r_stall_cnt;
    assign redirect_cnt = r_redirect_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: behavioural model checked every negedge,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pipe_hazard_ctrl;

    localparam int unsigned INIT_CYCLES = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_uses_rs1, id_uses_rs2, ex_memRead;
    logic        mem_branch, mem_zero, mem_bne, mem_jump, cnt_clr;
    logic        pc_write, pc_sel, if_id_write;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic [31:0] cycle_cnt, stall_cnt, redirect_cnt;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    pipe_hazard_ctrl #(.INIT_CYCLES(INIT_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_memRead(ex_memRead), .ex_rd(ex_rd),
        .mem_branch(mem_branch), .mem_zero(mem_zero),
        .mem_bne(mem_bne), .mem_jump(mem_jump),
        .cnt_clr(cnt_clr),
        .pc_write(pc_write), .pc_sel(pc_sel), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
        .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit          m_run;
    int          m_init_seen;
    logic [31:0] m_cycle, m_stall, m_redir;

    function automatic bit mdl_taken();
        if (mem_jump) return 1'b1;
        if (!mem_branch) return 1'b0;
        // beq takes when equal (zero), bne takes when not equal
        return mem_bne ? !mem_zero : mem_zero;
    endfunction

    function automatic bit mdl_load_use();
        bit hit;
        if (!ex_memRead || ex_rd == 5'd0) return 1'b0;
        hit = 1'b0;
        if (id_uses_rs1 && id_rs1 == ex_rd) hit = 1'b1;
        if (id_uses_rs2 && id_rs2 == ex_rd) hit = 1'b1;
        return hit;
    endfunction

    // {pc_write, pc_sel, if_id_write, if_id_f, id_ex_f, ex_mem_f, mem_wb_f}
    function automatic logic [6:0] mdl_ctrl();
        if (!rst_n || !m_run) return 7'b000_1111;
        if (mdl_taken())      return 7'b111_1110;
        if (mdl_load_use())   return 7'b000_0100;
        return 7'b101_0000;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 1'b0; m_init_seen = 0;
            m_cycle = '0; m_stall = '0; m_redir = '0;
        end else if (!m_run) begin
            m_init_seen++;
            if (m_init_seen == INIT_CYCLES) m_run = 1'b1;
        end else if (cnt_clr) begin
            m_cycle = '0; m_stall = '0; m_redir = '0;
        end else begin
            m_cycle++;
            if (mdl_taken()) m_redir++;
            else if (mdl_load_use()) m_stall++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] dut_ctrl();
        return {pc_write, pc_sel, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};
    endfunction

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (chk_on) begin
            chk("ctrl", 32'(dut_ctrl()), 32'(mdl_ctrl()));
            chk("cycle_cnt", cycle_cnt, m_cycle);
            chk("stall_cnt", stall_cnt, m_stall);
            chk("redirect_cnt", redirect_cnt, m_redir);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_memRead = 1'b0;
        mem_branch = 1'b0; mem_zero = 1'b0; mem_bne = 1'b0; mem_jump = 1'b0;
        cnt_clr = 1'b0;
    endtask

    task automatic set_load_use();
        ex_memRead = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    endtask

    task automatic check_init_window(input string tag);
        for (int i = 0; i < int'(INIT_CYCLES); i++) begin
            #3;
            chk({tag, "_init_ctrl"}, 32'(dut_ctrl()), 32'h0F);
            tick();
        end
        #3;
        chk({tag, "_first_run_ctrl"}, 32'(dut_ctrl()), 32'h50);
        chk({tag, "_first_run_cycle"}, cycle_cnt, 32'd0);
        tick();
        #3;
        chk({tag, "_cycle_after_edge"}, cycle_cnt, 32'd1);
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        chk_on = 1'b1;
        repeat (2) tick();
        #3;
        chk("reset_ctrl", 32'(dut_ctrl()), 32'h0F);
        chk("reset_cycle", cycle_cnt, 32'd0);
        tick();
        rst_n = 1'b1;
        check_init_window("fill");

        // load-use stall for one cycle, then resume
        set_load_use();
        #3;
        chk("lu_ctrl", 32'(dut_ctrl()), 32'h04);
        tick();
        ex_memRead = 1'b0;
        #3;
        chk("lu_resume_ctrl", 32'(dut_ctrl()), 32'h50);
        chk("lu_stall_cnt", stall_cnt, 32'd1);
        tick();

        // load to x0 never stalls
        idle_inputs();
        ex_memRead = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
        #3;
        chk("x0_ctrl", 32'(dut_ctrl()), 32'h50);
        tick();
        #3;
        chk("x0_stall_cnt", stall_cnt, 32'd1);

        // beq taken
        idle_inputs();
        mem_branch = 1'b1; mem_zero = 1'b1;
        #1;
        chk("beq_ctrl", 32'(dut_ctrl()), 32'h7E);
        tick();
        #3;
        chk("beq_redir", redirect_cnt, 32'd1);
        // bne with equal operands: not taken
        mem_bne = 1'b1;
        #1;
        chk("bne_ctrl", 32'(dut_ctrl()), 32'h50);
        tick();
        #3;
        chk("bne_redir", redirect_cnt, 32'd1);
        // jump alone
        idle_inputs();
        mem_jump = 1'b1;
        #1;
        chk("jump_ctrl", 32'(dut_ctrl()), 32'h7E);
        tick();
        #3;
        chk("jump_redir", redirect_cnt, 32'd2);

        // taken plus load-use: redirect only
        set_load_use();
        #1;
        chk("both_ctrl", 32'(dut_ctrl()), 32'h7E);
        tick();
        #3;
        chk("both_stall", stall_cnt, 32'd1);
        chk("both_redir", redirect_cnt, 32'd3);

        // clear plus taken
        idle_inputs();
        cnt_clr = 1'b1; mem_jump = 1'b1;
        tick();
        cnt_clr = 1'b0; mem_jump = 1'b0;
        #3;
        chk("clr_cycle", cycle_cnt, 32'd0);
        chk("clr_stall", stall_cnt, 32'd0);
        chk("clr_redir", redirect_cnt, 32'd0);
        tick();

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            ex_rd       = 5'($urandom_range(0, 3));
            id_uses_rs1 = 1'($urandom_range(0, 1));
            id_uses_rs2 = 1'($urandom_range(0, 1));
            ex_memRead  = 1'($urandom_range(0, 1));
            mem_branch  = ($urandom_range(0, 3) == 0);
            mem_zero    = 1'($urandom_range(0, 1));
            mem_bne     = 1'($urandom_range(0, 1));
            mem_jump    = ($urandom_range(0, 7) == 0);
            cnt_clr     = ($urandom_range(0, 63) == 0);
            tick();
        end

        // async reset during a load-use stall
        idle_inputs();
        set_load_use();
        #2;
        chk("pre_rst_ctrl", 32'(dut_ctrl()), 32'h04);
        rst_n = 1'b0;
        #1;
        chk("midrst_ctrl", 32'(dut_ctrl()), 32'h0F);
        chk("midrst_cycle", cycle_cnt, 32'd0);
        chk("midrst_stall", stall_cnt, 32'd0);
        chk("midrst_redir", redirect_cnt, 32'd0);
        repeat (2) tick();
        idle_inputs();
        rst_n = 1'b1;
        check_init_window("rerst");

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and pipeline-control unit for the 5-stage RV32 core. It watches the ID stage and the outputs of the ID_EX and EX_MEM pipeline registers, and drives stall, flush and redirect controls back into the PC and pipeline registers. It also runs a post-reset fill sequence, because the pipeline registers have no reset, and keeps event counters for the performance test bench.

## Interface
Parameters:
- INIT_CYCLES, 4, number of bubble-injecting cycles after reset (range 1..15)

Ports:
- clk  in  1  rising-edge clock; one clock for the whole block
- rst_n  in  1  asynchronous, active-low reset
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1 each  the ID instruction actually reads that source
- ex_memRead  in  1  memRead output of ID_EX
- ex_rd  in  5  rd output of ID_EX
- mem_branch, mem_zero, mem_bne, mem_jump  in  1 each  outputs of EX_MEM
- cnt_clr  in  1  synchronous clear of all counters
- pc_write  out  1  PC register loads on the next edge
- pc_sel  out  1  1 = PC loads the EX_MEM branch_destination; 0 = PC+4
- if_id_write  out  1  IF_ID loads on the next edge; 0 = IF_ID holds
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  the stage register captures a bubble: all control signals 0, data don't-care
- cycle_cnt, stall_cnt, redirect_cnt  out  32 each  event counters

## Operation
- FSM states: INIT, RUN.
- **Reset.** Reset forces state INIT, init_cnt=0 and all counters to 0.
- **INIT outputs.**
  - pc_write=0, pc_sel=0, if_id_write=0.
  - All four flush outputs are 1.
  - All stage inputs are ignored.
- **INIT sequencing.** init_cnt increments on each edge. At the edge where init_cnt==INIT_CYCLES-1, the state moves to RUN.
- **RUN decode.**
  - taken = mem_jump | (mem_branch & (mem_zero ^ mem_bne)).
  - load_use = ex_memRead & (ex_rd≠0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- **RUN priority 1, taken:**
  - pc_write=1, pc_sel=1, if_id_write=1.
  - if_id_flush, id_ex_flush and ex_mem_flush are 1; mem_wb_flush=0.
  - load_use is ignored, because the instruction in ID is squashed.
- **RUN priority 2, load_use:**
  - pc_write=0, if_id_write=0, id_ex_flush=1.
  - All other flush outputs are 0; pc_sel=0.
- **RUN otherwise:** pc_write=1, if_id_write=1, pc_sel=0, all flush outputs 0.
- **Counters**, in RUN only:
  - cycle_cnt increments every RUN cycle.
  - stall_cnt increments on cycles with load_use and not taken.
  - redirect_cnt increments on taken cycles.
  - All counters wrap modulo 2^32.
  - cnt_clr=1 writes 0 to every counter at the edge and overrides any increment in that cycle.
- No further state: a load-use stall lasts exactly one cycle, because the injected bubble clears ex_memRead.

## Timing
- All control outputs are combinational: from registered state plus current-cycle inputs (Mealy). They act at the next rising edge. Latency from hazard to corrective action is 0 cycles.
- Counters are registered and update at the edge that ends the event cycle.
- INIT occupies exactly INIT_CYCLES cycles after rst_n deasserts. The first RUN cycle follows edge number INIT_CYCLES.
- rst_n assertion mid-operation immediately (asynchronously) forces INIT outputs and zeroes the counters. The pipeline then refills from the reset PC.
- If taken and load_use occur in the same cycle: the redirect wins, and only redirect_cnt increments.
- A load whose rd is x0 never stalls.
- A taken branch with a load-use hazard present is still only one redirect event.

## Test plan
- **Reset fill:** INIT_CYCLES=4, rst_n low→high. Required:
  - Flush outputs are 1 and pc_write=0 for 4 cycles.
  - Cycle 5: pc_write=1, flushes 0, cycle_cnt starts at 0 and reads 1 after that edge.
- **Load-use:** ex_memRead=1, ex_rd=5, id_rs2=5, id_uses_rs2=1. Required:
  - That cycle: pc_write=0, if_id_write=0, id_ex_flush=1.
  - Next cycle, with ex_memRead=0: normal flow resumes; stall_cnt=1.
- **Load to x0:** ex_rd=0, id_rs1=0, id_uses_rs1=1, ex_memRead=1. Required: no stall; stall_cnt unchanged.
- **Branches:**
  - beq: mem_branch=1, mem_zero=1, mem_bne=0 → pc_sel=1, IF_ID/ID_EX/EX_MEM flushed, redirect_cnt+1.
  - bne: same inputs with mem_bne=1 → no redirect.
  - mem_jump=1 alone → redirect.
- **Simultaneous events:**
  - taken plus load_use in the same cycle → redirect outputs only; stall_cnt unchanged; redirect_cnt+1.
  - cnt_clr plus taken → all counters 0 after the edge.
- **Reset mid-run:** assert rst_n low during a load-use stall. Required: INIT outputs appear immediately, all counters read 0, and INIT lasts a full INIT_CYCLES after release.
